// File: rtl/gpr_cdb_arbiter_pkg.sv
// Shared GPR CDB types, unit count and fixed unit slots.
// Pure declarations: no latency, no backpressure.
package gpr_cdb_arbiter_pkg;

  localparam int ROB_WIDTH     = 6;
  localparam int GPR_CDB_N_REQ = 4;

  // Fixed request slots on the GPR CDB; later units take the next free index.
  localparam int UNIT_ADD_SUB = 0;
  localparam int UNIT_SHIFT   = 1;
  localparam int UNIT_MOV     = 2;
  localparam int UNIT_LOAD    = 3;

  typedef struct packed {
    logic                 valid;
    logic [ROB_WIDTH-1:0] tag;
    logic [31:0]          data;
  } cdb_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gpr_cdb_arbiter_rr_picker.sv
// Round-robin picker: first set request at or after ptr, wrapping modulo N_REQ.
// Purely combinational (0 cycles); no flow control of its own.
module gpr_cdb_arbiter_rr_picker #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // One spare bit so ptr+k cannot overflow before the single wrap subtraction.
  logic [IDX_W:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = {1'b0, ptr} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(N_REQ)) begin
        cand = cand - (IDX_W+1)'(N_REQ);
      end
      if (!any && req[cand[IDX_W-1:0]]) begin
        any                      = 1'b1;
        idx                      = cand[IDX_W-1:0];
        grant[cand[IDX_W-1:0]]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gpr_cdb_arbiter.sv
// GPR CDB arbiter: same-cycle round-robin grant, broadcast of the winner's result 1 cycle later.
// Units hold until req_ready; flush drops the grant and masks the pending broadcast.
module gpr_cdb_arbiter
  import gpr_cdb_arbiter_pkg::*;
#(
  parameter int N_REQ = GPR_CDB_N_REQ,
  parameter int IDX_W = idx_width(N_REQ),
  parameter int CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  cdb_t [N_REQ-1:0]       unit_result,
  input  logic                   flush,
  output cdb_t                   gpr_cdb,
  output logic [CNT_W-1:0]       busy_cnt
);

  logic [N_REQ-1:0] pick_grant;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] next_ptr;
  logic [IDX_W-1:0] grant_idx_q;
  logic             grant_v_q;
  logic             grant_fire;

  gpr_cdb_arbiter_rr_picker #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  assign grant_fire = pick_any && !flush;
  // Gated by reset_n so no unit dispatches into a CDB that is being reset.
  assign req_ready  = (grant_fire && reset_n) ? pick_grant : '0;
  assign next_ptr   = (pick_idx == IDX_W'(N_REQ - 1)) ? '0 : pick_idx + IDX_W'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr      <= '0;
      grant_v_q   <= 1'b0;
      grant_idx_q <= '0;
      busy_cnt    <= '0;
    end else begin
      grant_v_q <= grant_fire;
      if (grant_fire) begin
        grant_idx_q <= pick_idx;
        rr_ptr      <= next_ptr;
      end
      if (gpr_cdb.valid) begin
        busy_cnt <= busy_cnt + CNT_W'(1);
      end
    end
  end

  // Data comes straight from the unit's own result flop; only valid is ours.
  always_comb begin
    gpr_cdb = '0;
    if (grant_v_q && !flush) begin
      gpr_cdb       = unit_result[grant_idx_q];
      gpr_cdb.valid = 1'b1;
    end
  end

  a_ready_onehot: assert property (@(posedge clk) disable iff (!reset_n)
    $onehot0(req_ready));
  a_ready_needs_valid: assert property (@(posedge clk) disable iff (!reset_n)
    (req_ready & ~req_valid) == '0);

endmodule

// File: tb/tb_gpr_cdb_arbiter.sv
// Self-checking bench for gpr_cdb_arbiter with N_REQ=4.
// Expected broadcasts are queued at grant time and compared one cycle later.
module tb_gpr_cdb_arbiter;
  import gpr_cdb_arbiter_pkg::*;

  localparam int N = 4;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             flush;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  cdb_t [N-1:0]     unit_result;
  cdb_t             gpr_cdb;
  logic [31:0]      busy_cnt;

  int          checks = 0;
  int          errors = 0;
  cdb_t        exp_q[$];
  int unsigned exp_busy;

  always #5 clk = ~clk;

  gpr_cdb_arbiter #(
    .N_REQ (N),
    .IDX_W (2),
    .CNT_W (32)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .unit_result (unit_result),
    .flush       (flush),
    .gpr_cdb     (gpr_cdb),
    .busy_cnt    (busy_cnt)
  );

  function automatic cdb_t bcast(input logic [N-1:0] g);
    cdb_t c;
    c = '0;
    for (int i = 0; i < N; i++) begin
      if (g[i]) begin
        c.valid = 1'b1;
        c.tag   = ROB_WIDTH'(i);
        c.data  = 32'(100 + i);
      end
    end
    return c;
  endfunction

  task automatic do_reset();
    reset_n   = 1'b0;
    req_valid = '0;
    flush     = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;
    exp_q.delete();
    exp_q.push_back('0);
    exp_busy = 0;
  endtask

  // Queue what the bus must show next cycle, then move to the next cycle.
  task automatic commit(input logic [N-1:0] grant);
    exp_q.push_back(bcast(grant));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    cdb_t exp_c;
    reset_n   = 1'b0;
    req_valid = 4'b1111;
    flush     = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (req_ready !== 4'b0000) begin
        errors++; $display("FAIL reset_ready[%0d]: got %b want 0000", k, req_ready);
      end
      checks++;
      if (gpr_cdb !== cdb_t'('0)) begin
        errors++; $display("FAIL reset_cdb[%0d]: got %h want 0", k, gpr_cdb);
      end
      checks++;
      if (busy_cnt !== 32'd0) begin
        errors++; $display("FAIL reset_busy[%0d]: got %0d want 0", k, busy_cnt);
      end
      @(posedge clk);
    end
    #1 reset_n = 1'b1;
    exp_q.delete();
    exp_q.push_back('0);
    exp_busy = 0;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++; $display("FAIL reset_first_grant: got %b want 0001", req_ready);
    end
    exp_c = exp_q.pop_front();
    checks++;
    if (gpr_cdb !== exp_c) begin
      errors++; $display("FAIL reset_first_cdb: got %h want %h", gpr_cdb, exp_c);
    end
    commit(4'b0001);
    req_valid = '0;
    #1;
    exp_c = exp_q.pop_front();
    checks++;
    if (gpr_cdb !== exp_c) begin
      errors++; $display("FAIL reset_first_bcast: got %h want %h", gpr_cdb, exp_c);
    end
    commit(4'b0000);
  endtask

  task automatic test_round_robin();
    logic [N-1:0] rq [10] = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'h0, 4'h0};
    logic [N-1:0] er [10] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4, 4'h8, 4'h0, 4'h0};
    cdb_t exp_c;
    do_reset();
    for (int k = 0; k < 10; k++) begin
      req_valid = rq[k]; flush = 1'b0; #1;
      checks++;
      if (req_ready !== er[k]) begin
        errors++; $display("FAIL rr_ready[%0d]: got %b want %b", k, req_ready, er[k]);
      end
      exp_c = exp_q.pop_front();
      checks++;
      if (gpr_cdb !== exp_c) begin
        errors++; $display("FAIL rr_cdb[%0d]: got %h want %h", k, gpr_cdb, exp_c);
      end
      checks++;
      if (busy_cnt !== exp_busy) begin
        errors++; $display("FAIL rr_busy[%0d]: got %0d want %0d", k, busy_cnt, exp_busy);
      end
      if (exp_c.valid) exp_busy++;
      commit(er[k]);
    end
    checks++;
    if (busy_cnt !== 32'd8) begin
      errors++; $display("FAIL rr_busy_total: got %0d want 8", busy_cnt);
    end
  endtask

  task automatic test_sparse_wrap();
    logic [N-1:0] rq [4] = '{4'b0100, 4'b0011, 4'b0011, 4'b0000};
    logic [N-1:0] er [4] = '{4'b0100, 4'b0001, 4'b0010, 4'b0000};
    cdb_t exp_c;
    for (int k = 0; k < 4; k++) begin
      req_valid = rq[k]; flush = 1'b0; #1;
      checks++;
      if (req_ready !== er[k]) begin
        errors++; $display("FAIL sparse_ready[%0d]: got %b want %b", k, req_ready, er[k]);
      end
      exp_c = exp_q.pop_front();
      checks++;
      if (gpr_cdb !== exp_c) begin
        errors++; $display("FAIL sparse_cdb[%0d]: got %h want %h", k, gpr_cdb, exp_c);
      end
      if (exp_c.valid) exp_busy++;
      commit(er[k]);
    end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] rq [5] = '{4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000};
    logic [N-1:0] er [5] = '{4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000};
    cdb_t exp_c;
    for (int k = 0; k < 5; k++) begin
      req_valid = rq[k]; flush = 1'b0; #1;
      checks++;
      if (req_ready !== er[k]) begin
        errors++; $display("FAIL b2b_ready[%0d]: got %b want %b", k, req_ready, er[k]);
      end
      exp_c = exp_q.pop_front();
      checks++;
      if (gpr_cdb !== exp_c) begin
        errors++; $display("FAIL b2b_cdb[%0d]: got %h want %h", k, gpr_cdb, exp_c);
      end
      checks++;
      if (busy_cnt !== exp_busy) begin
        errors++; $display("FAIL b2b_busy[%0d]: got %0d want %0d", k, busy_cnt, exp_busy);
      end
      if (exp_c.valid) exp_busy++;
      commit(er[k]);
    end
  endtask

  task automatic test_flush();
    logic [N-1:0] rq [5] = '{4'b0010, 4'b1111, 4'b1111, 4'b0000, 4'b0000};
    logic         fl [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [N-1:0] er [5] = '{4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b0000};
    cdb_t exp_c;
    for (int k = 0; k < 5; k++) begin
      req_valid = rq[k]; flush = fl[k]; #1;
      checks++;
      if (req_ready !== er[k]) begin
        errors++; $display("FAIL flush_ready[%0d]: got %b want %b", k, req_ready, er[k]);
      end
      exp_c = exp_q.pop_front();
      if (fl[k]) exp_c = '0;
      checks++;
      if (gpr_cdb !== exp_c) begin
        errors++; $display("FAIL flush_cdb[%0d]: got %h want %h", k, gpr_cdb, exp_c);
      end
      checks++;
      if (busy_cnt !== exp_busy) begin
        errors++; $display("FAIL flush_busy[%0d]: got %0d want %0d", k, busy_cnt, exp_busy);
      end
      if (exp_c.valid) exp_busy++;
      commit(er[k]);
    end
    flush = 1'b0;
  endtask

  task automatic test_idle();
    logic [N-1:0] rq [4] = '{4'b0000, 4'b0000, 4'b1111, 4'b0000};
    logic [N-1:0] er [4] = '{4'b0000, 4'b0000, 4'b1000, 4'b0000};
    cdb_t exp_c;
    for (int k = 0; k < 4; k++) begin
      req_valid = rq[k]; flush = 1'b0; #1;
      checks++;
      if (req_ready !== er[k]) begin
        errors++; $display("FAIL idle_ready[%0d]: got %b want %b", k, req_ready, er[k]);
      end
      exp_c = exp_q.pop_front();
      checks++;
      if (gpr_cdb !== exp_c) begin
        errors++; $display("FAIL idle_cdb[%0d]: got %h want %h", k, gpr_cdb, exp_c);
      end
      if (exp_c.valid) exp_busy++;
      commit(er[k]);
    end
  endtask

  task automatic test_reset_mid_broadcast();
    req_valid = 4'b0100; flush = 1'b0; #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++; $display("FAIL midrst_grant: got %b want 0100", req_ready);
    end
    @(posedge clk);
    #1 reset_n = 1'b0;
    req_valid = 4'b1111;
    #1;
    checks++;
    if (gpr_cdb !== cdb_t'('0)) begin
      errors++; $display("FAIL midrst_cdb_in_reset: got %h want 0", gpr_cdb);
    end
    checks++;
    if (req_ready !== 4'b0000) begin
      errors++; $display("FAIL midrst_ready_in_reset: got %b want 0000", req_ready);
    end
    @(posedge clk);
    #1 reset_n = 1'b1;
    #1;
    checks++;
    if (gpr_cdb.valid !== 1'b0) begin
      errors++; $display("FAIL midrst_cdb_after: got %b want 0", gpr_cdb.valid);
    end
    checks++;
    if (busy_cnt !== 32'd0) begin
      errors++; $display("FAIL midrst_busy_after: got %0d want 0", busy_cnt);
    end
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++; $display("FAIL midrst_ptr_after: got %b want 0001", req_ready);
    end
    @(posedge clk);
    #1 req_valid = '0;
  endtask

  initial begin
    reset_n   = 1'b0;
    flush     = 1'b0;
    req_valid = '0;
    exp_busy  = 0;
    for (int i = 0; i < N; i++) begin
      unit_result[i].valid = 1'b1;
      unit_result[i].tag   = ROB_WIDTH'(i);
      unit_result[i].data  = 32'(100 + i);
    end
    test_reset();
    test_round_robin();
    test_sparse_wrap();
    test_back_to_back();
    test_flush();
    test_idle();
    test_reset_mid_broadcast();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
